// File: rtl/aemb2_dwbif.sv
// aemb2_dwbif: AEMB2 data-side Wishbone master with big-endian lane steering,
// load alignment and pipeline stall generation. Rev 1.0
`default_nettype none

module aemb2_dwbif #(
   parameter int AEMB_DWB = 32
) (
   input  logic                  gclk,
   input  logic                  grst,
   input  logic                  ld_ex,
   input  logic                  st_ex,
   input  logic [1:0]            siz_ex,
   input  logic [AEMB_DWB-1:0]   add_ex,
   input  logic [31:0]           opd_of,
   output logic                  dena,
   output logic [AEMB_DWB-1:2]   dwb_adr_o,
   output logic [3:0]            dwb_sel_o,
   output logic [31:0]           dwb_dat_o,
   output logic                  dwb_wre_o,
   output logic                  dwb_stb_o,
   output logic                  dwb_cyc_o,
   input  logic                  dwb_ack_i,
   input  logic [31:0]           dwb_dat_i,
   output logic [31:0]           dwb_mx,
   output logic [3:0]            sel_mx
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic [3:0]  sel_nxt;
   logic [31:0] dat_nxt;
   logic [31:0] ld_align;

   assign dwb_stb_o = (state == S_WAIT);
   assign dwb_cyc_o = dwb_stb_o;
   assign dena      = ~dwb_stb_o | dwb_ack_i;
   assign accept    = dena & (ld_ex | st_ex);

   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (accept)
         state_nxt = S_WAIT;
      else if ((state == S_WAIT) && dwb_ack_i)
         state_nxt = S_IDLE;
   end

   // Big-endian steering: byte 0 of the word lives on lane [31:24].
   always_comb begin
      sel_nxt = 4'b1111;
      dat_nxt = opd_of;
      case (siz_ex)
         2'b00: begin
            sel_nxt = 4'b1000 >> add_ex[1:0];
            dat_nxt = {4{opd_of[7:0]}};
         end
         2'b01: begin
            sel_nxt = add_ex[1] ? 4'b0011 : 4'b1100;
            dat_nxt = {2{opd_of[15:0]}};
         end
         default: begin
            sel_nxt = 4'b1111;
            dat_nxt = opd_of;
         end
      endcase
   end

   // The registered lane select fully encodes size and offset for alignment.
   always_comb begin
      ld_align = dwb_dat_i;
      case (dwb_sel_o)
         4'b1000: ld_align = {24'h0, dwb_dat_i[31:24]};
         4'b0100: ld_align = {24'h0, dwb_dat_i[23:16]};
         4'b0010: ld_align = {24'h0, dwb_dat_i[15:8]};
         4'b0001: ld_align = {24'h0, dwb_dat_i[7:0]};
         4'b1100: ld_align = {16'h0, dwb_dat_i[31:16]};
         4'b0011: ld_align = {16'h0, dwb_dat_i[15:0]};
         default: ld_align = dwb_dat_i;
      endcase
   end

   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         dwb_adr_o <= '0;
         dwb_sel_o <= 4'h0;
         dwb_dat_o <= 32'h0;
         dwb_wre_o <= 1'b0;
      end else if (accept) begin
         dwb_adr_o <= add_ex[AEMB_DWB-1:2];
         dwb_sel_o <= sel_nxt;
         dwb_dat_o <= dat_nxt;
         dwb_wre_o <= ~ld_ex;
      end
   end

   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         dwb_mx <= 32'h0;
         sel_mx <= 4'h0;
      end else if ((state == S_WAIT) && dwb_ack_i) begin
         sel_mx <= dwb_sel_o;
         if (!dwb_wre_o) dwb_mx <= ld_align;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_aemb2_dwbif.sv
// Directed self-checking bench for aemb2_dwbif.
`default_nettype none

module tb_aemb2_dwbif;

   logic        gclk = 1'b0;
   logic        grst = 1'b0;
   logic        ld_ex = 1'b0;
   logic        st_ex = 1'b0;
   logic [1:0]  siz_ex = 2'b00;
   logic [31:0] add_ex = 32'h0;
   logic [31:0] opd_of = 32'h0;
   logic        dena;
   logic [31:2] dwb_adr_o;
   logic [3:0]  dwb_sel_o;
   logic [31:0] dwb_dat_o;
   logic        dwb_wre_o;
   logic        dwb_stb_o;
   logic        dwb_cyc_o;
   logic        dwb_ack_i = 1'b0;
   logic [31:0] dwb_dat_i = 32'h0;
   logic [31:0] dwb_mx;
   logic [3:0]  sel_mx;

   int checks = 0;
   int errors = 0;

   aemb2_dwbif #(.AEMB_DWB(32)) dut (
      .gclk(gclk), .grst(grst), .ld_ex(ld_ex), .st_ex(st_ex), .siz_ex(siz_ex),
      .add_ex(add_ex), .opd_of(opd_of), .dena(dena), .dwb_adr_o(dwb_adr_o),
      .dwb_sel_o(dwb_sel_o), .dwb_dat_o(dwb_dat_o), .dwb_wre_o(dwb_wre_o),
      .dwb_stb_o(dwb_stb_o), .dwb_cyc_o(dwb_cyc_o), .dwb_ack_i(dwb_ack_i),
      .dwb_dat_i(dwb_dat_i), .dwb_mx(dwb_mx), .sel_mx(sel_mx)
   );

   always #5 gclk = ~gclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge gclk);
      #1;
   endtask

   logic [31:0] byte_exp [4];
   logic [3:0]  sel_exp  [4];

   initial begin
      byte_exp[0] = 32'h11; byte_exp[1] = 32'h22; byte_exp[2] = 32'h33; byte_exp[3] = 32'h44;
      sel_exp[0] = 4'b1000; sel_exp[1] = 4'b0100; sel_exp[2] = 4'b0010; sel_exp[3] = 4'b0001;

      // Reset state
      #12;
      chk("rst_stb", {31'h0, dwb_stb_o}, 32'h0);
      chk("rst_cyc", {31'h0, dwb_cyc_o}, 32'h0);
      chk("rst_dena", {31'h0, dena}, 32'h1);
      chk("rst_adr", {2'b00, dwb_adr_o}, 32'h0);
      chk("rst_mx", dwb_mx, 32'h0);
      grst = 1'b1;
      step();

      // Word load with two wait states
      ld_ex = 1'b1; siz_ex = 2'b10; add_ex = 32'h100;
      step();
      ld_ex = 1'b0;
      chk("wl_stb", {31'h0, dwb_stb_o}, 32'h1);
      chk("wl_adr", {2'b00, dwb_adr_o}, 32'h40);
      chk("wl_sel", {28'h0, dwb_sel_o}, 32'hF);
      chk("wl_wre", {31'h0, dwb_wre_o}, 32'h0);
      chk("wl_dena_w1", {31'h0, dena}, 32'h0);
      step();
      chk("wl_dena_w2", {31'h0, dena}, 32'h0);
      chk("wl_adr_hold", {2'b00, dwb_adr_o}, 32'h40);
      step();
      dwb_ack_i = 1'b1; dwb_dat_i = 32'hDEADBEEF;
      #1;
      chk("wl_dena_ack", {31'h0, dena}, 32'h1);
      step();
      dwb_ack_i = 1'b0;
      chk("wl_mx", dwb_mx, 32'hDEADBEEF);
      chk("wl_selmx", {28'h0, sel_mx}, 32'hF);
      chk("wl_idle", {31'h0, dwb_stb_o}, 32'h0);

      // Byte loads at offsets 0..3
      for (int i = 0; i < 4; i++) begin
         ld_ex = 1'b1; siz_ex = 2'b00; add_ex = 32'h300 + i;
         step();
         ld_ex = 1'b0;
         chk($sformatf("bl_sel%0d", i), {28'h0, dwb_sel_o}, {28'h0, sel_exp[i]});
         dwb_ack_i = 1'b1; dwb_dat_i = 32'h11223344;
         step();
         dwb_ack_i = 1'b0;
         chk($sformatf("bl_mx%0d", i), dwb_mx, byte_exp[i]);
      end

      // Half store
      st_ex = 1'b1; siz_ex = 2'b01; add_ex = 32'h202; opd_of = 32'hCAFEBABE;
      step();
      st_ex = 1'b0;
      chk("hs_sel", {28'h0, dwb_sel_o}, 32'h3);
      chk("hs_dat", dwb_dat_o, 32'hBABEBABE);
      chk("hs_wre", {31'h0, dwb_wre_o}, 32'h1);
      chk("hs_adr", {2'b00, dwb_adr_o}, 32'h80);
      dwb_ack_i = 1'b1; dwb_dat_i = 32'h99999999;
      step();
      dwb_ack_i = 1'b0;
      chk("hs_mx_hold", dwb_mx, 32'h44);
      chk("hs_selmx", {28'h0, sel_mx}, 32'h3);

      // Back-to-back load, store, load with zero-wait slave
      ld_ex = 1'b1; siz_ex = 2'b10; add_ex = 32'h400;
      step();
      chk("bb_stb1", {31'h0, dwb_stb_o}, 32'h1);
      chk("bb_adr1", {2'b00, dwb_adr_o}, 32'h100);
      ld_ex = 1'b0; st_ex = 1'b1; add_ex = 32'h404; opd_of = 32'h12345678;
      dwb_ack_i = 1'b1; dwb_dat_i = 32'hA5A50001;
      #1;
      chk("bb_dena1", {31'h0, dena}, 32'h1);
      step();
      chk("bb_stb2", {31'h0, dwb_stb_o}, 32'h1);
      chk("bb_wre2", {31'h0, dwb_wre_o}, 32'h1);
      chk("bb_dat2", dwb_dat_o, 32'h12345678);
      chk("bb_mx1", dwb_mx, 32'hA5A50001);
      ld_ex = 1'b1; st_ex = 1'b0; add_ex = 32'h408; dwb_dat_i = 32'hFFFF0000;
      #1;
      chk("bb_dena2", {31'h0, dena}, 32'h1);
      step();
      chk("bb_stb3", {31'h0, dwb_stb_o}, 32'h1);
      chk("bb_wre3", {31'h0, dwb_wre_o}, 32'h0);
      chk("bb_adr3", {2'b00, dwb_adr_o}, 32'h102);
      chk("bb_mx_st", dwb_mx, 32'hA5A50001);
      ld_ex = 1'b0; dwb_dat_i = 32'h0BADF00D;
      #1;
      chk("bb_dena3", {31'h0, dena}, 32'h1);
      step();
      dwb_ack_i = 1'b0;
      chk("bb_mx2", dwb_mx, 32'h0BADF00D);
      chk("bb_idle", {31'h0, dwb_stb_o}, 32'h0);

      // Simultaneous load and store: load wins
      ld_ex = 1'b1; st_ex = 1'b1; siz_ex = 2'b11; add_ex = 32'h10;
      step();
      ld_ex = 1'b0; st_ex = 1'b0;
      chk("ls_wre", {31'h0, dwb_wre_o}, 32'h0);
      chk("ls_sel", {28'h0, dwb_sel_o}, 32'hF);
      dwb_ack_i = 1'b1; dwb_dat_i = 32'h00000055;
      step();
      dwb_ack_i = 1'b0;
      chk("ls_mx", dwb_mx, 32'h55);

      // Spurious ack in IDLE
      dwb_ack_i = 1'b1; dwb_dat_i = 32'hFFFFFFFF;
      step();
      dwb_ack_i = 1'b0;
      chk("sp_stb", {31'h0, dwb_stb_o}, 32'h0);
      chk("sp_mx", dwb_mx, 32'h55);
      chk("sp_selmx", {28'h0, sel_mx}, 32'hF);

      // Reset during WAIT, then late ack
      ld_ex = 1'b1; siz_ex = 2'b10; add_ex = 32'h20;
      step();
      ld_ex = 1'b0;
      chk("ra_stb", {31'h0, dwb_stb_o}, 32'h1);
      #2 grst = 1'b0;
      #1;
      chk("ra_stb0", {31'h0, dwb_stb_o}, 32'h0);
      chk("ra_cyc0", {31'h0, dwb_cyc_o}, 32'h0);
      chk("ra_dena", {31'h0, dena}, 32'h1);
      chk("ra_adr", {2'b00, dwb_adr_o}, 32'h0);
      chk("ra_mx", dwb_mx, 32'h0);
      chk("ra_selmx", {28'h0, sel_mx}, 32'h0);
      step();
      grst = 1'b1; dwb_ack_i = 1'b1; dwb_dat_i = 32'h77777777;
      step();
      dwb_ack_i = 1'b0;
      chk("la_stb", {31'h0, dwb_stb_o}, 32'h0);
      chk("la_mx", dwb_mx, 32'h0);
      chk("la_selmx", {28'h0, sel_mx}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
